// File: rtl/mc_pkg.sv
// Shared types and constants for the multicast bus controller.
package mc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } mc_state_t;

  localparam int DROP_W = 16;

  // All-ones tag of the requested width, used as the broadcast tag.
  function automatic logic [31:0] MC_BCAST_TAG(input int tag_w);
    return (32'd1 << tag_w) - 32'd1;
  endfunction

endpackage

// File: rtl/mc_fifo.sv
// Synchronous FIFO with combinational head read and synchronous active-high reset.
module mc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mc_bus_controller.sv
// Multicast bus controller: routes tagged FIFO entries to every PE whose configured ID matches.
// Optional feature macro: MC_BROADCAST_EN (all-ones tag reaches every enabled PE).
module mc_bus_controller
  import mc_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int TAG_W      = 4,
  parameter int NUM_PE     = 12,
  parameter int FIFO_DEPTH = 2,
  localparam int IDX_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [TAG_W-1:0]  cfg_id,
  input  logic              cfg_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_val,
  output logic [NUM_PE-1:0] pe_valid,
  input  logic [NUM_PE-1:0] pe_ready,
  output logic [DATA_W-1:0] pe_data,
  output logic [15:0]       drop_cnt,
  output logic              dbg_state
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } pkt_t;

  localparam int PKT_W = $bits(pkt_t);

`ifdef MC_BROADCAST_EN
  localparam logic [TAG_W-1:0] BCAST = TAG_W'(MC_BCAST_TAG(TAG_W));
`endif

  pkt_t              in_pkt, head;
  logic              fifo_full, fifo_empty;
  logic              pop, drop_inc, latch;
  logic [TAG_W-1:0]  id_q [NUM_PE];
  logic [NUM_PE-1:0] en_q;
  logic [NUM_PE-1:0] match, pending_q, pending_nxt;
  logic [DATA_W-1:0] pe_data_q;
  logic [DROP_W-1:0] drop_cnt_q;
  mc_state_t         state_q, state_d;

  assign in_pkt = '{tag: in_tag, val: in_val};

  mc_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_pkt),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PE; i++) id_q[i] <= '0;
      en_q <= '0;
    end else if (cfg_we && (32'(cfg_idx) < 32'(NUM_PE))) begin
      id_q[cfg_idx] <= cfg_id;
      en_q[cfg_idx] <= cfg_en;
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_PE; i++) begin
`ifdef MC_BROADCAST_EN
      match[i] = en_q[i] && ((id_q[i] == head.tag) || (head.tag == BCAST));
`else
      match[i] = en_q[i] && (id_q[i] == head.tag);
`endif
    end
  end

  // PEs that accept are removed so they are never re-offered the same packet.
  assign pending_nxt = pending_q & ~pe_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!fifo_empty && (match != '0)) state_d = SEND;
      SEND: if (pending_nxt == '0)             state_d = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    drop_inc = 1'b0;
    latch    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (match == '0) begin
            pop      = 1'b1;
            drop_inc = 1'b1;
          end else begin
            latch = 1'b1;
          end
        end
      end
      SEND: pop = (pending_nxt == '0);
    endcase
  end

  // Mask is captured once per packet; later config writes affect only later packets.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      pe_data_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (latch) begin
        pending_q <= match;
        pe_data_q <= head.val;
      end else if (state_q == SEND) begin
        pending_q <= pending_nxt;
      end
      if (drop_inc && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
    end
  end

  assign pe_valid  = pending_q;
  assign pe_data   = pe_data_q;
  assign drop_cnt  = drop_cnt_q;
  assign dbg_state = (state_q == SEND);

endmodule

// File: tb/tb_mc_bus_controller.sv
// Self-checking bench for mc_bus_controller: directed packets, handshake scoreboard.
module tb_mc_bus_controller;

  localparam int DATA_W = 16;
  localparam int TAG_W  = 4;
  localparam int NUM_PE = 12;
  localparam int FIFO_DEPTH = 2;
  localparam int IDX_W  = 4;
  localparam int SB_W   = NUM_PE + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [TAG_W-1:0]  cfg_id;
  logic              cfg_en;
  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] in_val;
  logic [NUM_PE-1:0] pe_valid;
  logic [NUM_PE-1:0] pe_ready;
  logic [DATA_W-1:0] pe_data;
  logic [15:0]       drop_cnt;
  logic              dbg_state;

  logic [SB_W-1:0]   exp_q[$];
  logic [SB_W-1:0]   mon_exp;
  logic [NUM_PE-1:0] mon_hs;
  int checks = 0;
  int errors = 0;
  int accepted;
  bit acc_now;

  mc_bus_controller #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_PE(NUM_PE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_id(cfg_id),
    .cfg_en(cfg_en), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_val(in_val), .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_data(pe_data),
    .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic cfg_write(input int idx, input int id, input bit en);
    cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_id = TAG_W'(id); cfg_en = en;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic push_exp(input logic [NUM_PE-1:0] mask, input logic [DATA_W-1:0] data);
    exp_q.push_back({mask, data});
  endtask

  task automatic send(input int tag, input logic [DATA_W-1:0] val);
    int n = 0;
    while (!in_ready && n < 50) begin cycle(); n++; end
    chk("send_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_tag = TAG_W'(tag); in_val = val;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (pe_valid == '0 && n < 20) begin cycle(); n++; end
    chk(nm, 32'(pe_valid != '0), 1);
  endtask

  task automatic stream(input int n);
    int cnt = 0;
    int guard = 0;
    in_valid = 1'b1; in_tag = 4'h9; in_val = 16'h0909;
    while (cnt < n && guard < 4 * n + 20) begin
      acc_now = in_ready;
      cycle();
      if (acc_now) cnt++;
      guard++;
    end
    in_valid = 1'b0;
    chk("stream_done", 32'(cnt), 32'(n));
  endtask

  // scoreboard monitor: every handshake cycle pops one expected {accept mask, data}
  always @(negedge clk) begin
    if (!rst) begin
      mon_hs = pe_valid & pe_ready;
      if (mon_hs != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%0h required=none", mon_hs);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("sb_mask", 32'(mon_hs), 32'(mon_exp[SB_W-1:DATA_W]));
          chk("sb_data", 32'(pe_data), 32'(mon_exp[DATA_W-1:0]));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_id = '0; cfg_en = 1'b0;
    in_valid = 1'b0; in_tag = '0; in_val = '0; pe_ready = '0;
    idle(3);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_pe_valid", 32'(pe_valid), 0);
    chk("rst_pe_data", 32'(pe_data), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    chk("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;
    cycle();

    for (int i = 0; i < 4; i++) cfg_write(i, 5, 1'b1);

    // single delivery, all ready
    pe_ready = '1;
    push_exp(12'h00F, 16'hABCD);
    send(5, 16'hABCD);
    chk("t1_lat_e0", 32'(pe_valid), 0);
    cycle();
    chk("t1_valid", 32'(pe_valid), 32'h00F);
    chk("t1_data", 32'(pe_data), 32'hABCD);
    cycle();
    chk("t1_one_cycle", 32'(pe_valid), 0);
    idle(2);

    // partial acceptance: only PE2 ready for three cycles
    pe_ready = 12'h004;
    push_exp(12'h004, 16'h1234);
    push_exp(12'h00B, 16'h1234);
    send(5, 16'h1234);
    wait_valid("t2_wait");
    chk("t2_first", 32'(pe_valid), 32'h00F);
    cycle(); chk("t2_held1", 32'(pe_valid), 32'h00B);
    cycle(); chk("t2_held2", 32'(pe_valid), 32'h00B);
    cycle(); chk("t2_held3", 32'(pe_valid), 32'h00B);
    pe_ready = '1;
    cycle(); chk("t2_done", 32'(pe_valid), 0);
    idle(2);

    // fill FIFO while stalled
    pe_ready = '0;
    push_exp(12'h00F, 16'h1111);
    push_exp(12'h00F, 16'h2222);
    accepted = 0;
    in_valid = 1'b1; in_tag = 4'h5;
    for (int k = 0; k < 6; k++) begin
      in_val = 16'h1111 * 16'(accepted + 1);
      acc_now = in_ready;
      cycle();
      if (acc_now) accepted++;
    end
    in_valid = 1'b0;
    chk("t4_accepted", 32'(accepted), 32'(FIFO_DEPTH));
    chk("t4_full", 32'(in_ready), 0);
    pe_ready = '1;
    cycle();
    chk("t4_ready_back", 32'(in_ready), 1);
    idle(6);

    // config write during SEND does not alter the latched mask
    pe_ready = '0;
    push_exp(12'h00F, 16'h5555);
    send(5, 16'h5555);
    wait_valid("t5_wait");
    cfg_write(0, 7, 1'b1);
    idle(2);
    pe_ready = '1;
    cycle();
    push_exp(12'h00E, 16'h6666);
    send(5, 16'h6666);
    idle(4);

    // unmatched packets are dropped
    chk("t3_drop_before", 32'(drop_cnt), 0);
    send(9, 16'h0001);
    send(9, 16'h0002);
    send(9, 16'h0003);
    idle(3);
    chk("t3_drop3", 32'(drop_cnt), 3);

    // all-ones tag
    cfg_write(5, 15, 1'b1);
    cfg_write(6, 15, 1'b0);
`ifdef MC_BROADCAST_EN
    push_exp(12'h02F, 16'hBEEF);
`else
    push_exp(12'h020, 16'hBEEF);
`endif
    send(15, 16'hBEEF);
    idle(4);

    // saturation of drop counter
    stream(65531);
    idle(3);
    chk("sat_fffe", 32'(drop_cnt), 32'hFFFE);
    stream(1);
    idle(3);
    chk("sat_ffff", 32'(drop_cnt), 32'hFFFF);
    stream(4);
    idle(3);
    chk("sat_hold", 32'(drop_cnt), 32'hFFFF);

    // reset while a packet is being offered
    pe_ready = '0;
    send(5, 16'h7777);
    wait_valid("rst_mid_wait");
    send(5, 16'h8888);
    rst = 1'b1;
    cycle();
    chk("rstm_pe_valid", 32'(pe_valid), 0);
    chk("rstm_in_ready", 32'(in_ready), 1);
    chk("rstm_drop_cnt", 32'(drop_cnt), 0);
    chk("rstm_state", 32'(dbg_state), 0);
    rst = 1'b0;
    pe_ready = '1;
    cycle();
    send(5, 16'h9999);
    idle(3);
    chk("rstm_cfg_cleared", 32'(drop_cnt), 1);

    idle(5);
    chk("sb_drained", 32'(exp_q.size()), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
